// File: rtl/ethernet_icmp_reply_transmitter_pkg.sv
// Shared constants and FSM state type for the ICMP echo reply transmitter.
package ethernet_icmp_reply_transmitter_pkg;

  localparam int HEAD_BYTES  = 50;
  localparam int PAYLOAD_MAX = 63;
  localparam int WORD_BYTES  = 8;
  localparam int BUF_BITS    = (HEAD_BYTES + PAYLOAD_MAX) * 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/ethernet_tx_keep_gen.sv
// Byte-valid mask for a transmit word: all bytes on non-final words, R leading bytes on the final one.
module ethernet_tx_keep_gen
  import ethernet_icmp_reply_transmitter_pkg::*;
(
  input  logic                  i_last,
  input  logic [2:0]            i_rem,
  output logic [WORD_BYTES-1:0] o_keep
);

  // A remainder of zero means the final word is completely filled.
  always_comb begin
    o_keep = {WORD_BYTES{1'b1}};
    if (i_last && (i_rem != 3'd0)) begin
      o_keep = ~({WORD_BYTES{1'b1}} >> i_rem);
    end
  end

endmodule

// File: rtl/ethernet_icmp_reply_transmitter.sv
// Captures a finished ICMP echo reply (head + payload) and streams it as 64-bit words to the TX MAC.
module ethernet_icmp_reply_transmitter #(
  parameter int HEAD_BYTES  = ethernet_icmp_reply_transmitter_pkg::HEAD_BYTES,
  parameter int PAYLOAD_MAX = ethernet_icmp_reply_transmitter_pkg::PAYLOAD_MAX,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_icmp_reply_ready,
  input  logic [HEAD_BYTES*8-1:0]    i_icmp_reply_head,
  input  logic [PAYLOAD_MAX*8-1:0]   i_icmp_reply_payload,
  input  logic [5:0]                 i_icmp_payload_size,
  output logic                       o_tx_valid,
  input  logic                       i_tx_ready,
  output logic [63:0]                o_tx_data,
  output logic [7:0]                 o_tx_keep,
  output logic                       o_tx_last,
  output logic                       o_busy,
  output logic [DROP_CNT_W-1:0]      o_dropped
);

  import ethernet_icmp_reply_transmitter_pkg::*;

  tx_state_t               state_q, state_d;
  logic [BUF_BITS-1:0]     buf_q, buf_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [2:0]              rem_q, rem_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;

  logic                    load;
  logic                    hs;
  logic                    last_word;
  logic [6:0]              frame_len;
  logic [3:0]              words_m1;
  logic [PAYLOAD_MAX*8-1:0] pay_mask;
  logic [7:0]              keep_raw;

  // Handshake: a word transfers on the rising edge where o_tx_valid and i_tx_ready are both high;
  // while valid is high and ready is low every output holds its value.
  assign hs        = (state_q == SEND) && i_tx_ready;
  assign last_word = (state_q == SEND) && (cnt_q == 4'd0);

  assign frame_len = 7'(HEAD_BYTES) + {1'b0, i_icmp_payload_size};
  assign words_m1  = 4'((frame_len + 7'd7) >> 3) - 4'd1;
  // Keep only the first N payload bytes so bytes past the frame end leave as zero.
  assign pay_mask  = ~({(PAYLOAD_MAX*8){1'b1}} >> {i_icmp_payload_size, 3'b000});

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    drop_d  = drop_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_icmp_reply_ready) load = 1'b1;
      end
      SEND: begin
        if (hs) begin
          buf_d = buf_q << (WORD_BYTES * 8);
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            if (i_icmp_reply_ready) load = 1'b1;
            else                    state_d = IDLE;
          end
        end
        // A strobe landing on the final handshake chains the next frame instead of dropping.
        if (i_icmp_reply_ready && !(hs && (cnt_q == 4'd0)) && !(&drop_q)) begin
          drop_d = drop_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      buf_d   = {i_icmp_reply_head, i_icmp_reply_payload & pay_mask};
      cnt_d   = words_m1;
      rem_d   = frame_len[2:0];
      state_d = SEND;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  ethernet_tx_keep_gen u_keep_gen (
    .i_last (last_word),
    .i_rem  (rem_q),
    .o_keep (keep_raw)
  );

  assign o_tx_valid = (state_q == SEND);
  assign o_busy     = (state_q == SEND);
  assign o_tx_last  = last_word;
  assign o_tx_keep  = o_tx_valid ? keep_raw : 8'h00;
  assign o_tx_data  = buf_q[BUF_BITS-1 -: 64];
  assign o_dropped  = drop_q;

endmodule

// File: tb/tb_ethernet_icmp_reply_transmitter.sv
// Randomized scoreboard bench for the ICMP echo reply transmitter against a byte-array frame model.
module tb_ethernet_icmp_reply_transmitter;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         strobe = 1'b0;
  logic [399:0] head = '0;
  logic [503:0] pay = '0;
  logic [5:0]   size = '0;
  logic         i_tx_ready = 1'b0;
  logic         o_tx_valid;
  logic [63:0]  o_tx_data;
  logic [7:0]   o_tx_keep;
  logic         o_tx_last;
  logic         o_busy;
  logic [7:0]   o_dropped;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [72:0]  exp_q[$];
  int           exp_drop = 0;
  bit           mon_en = 0;
  int           ready_mode = 0;

  ethernet_icmp_reply_transmitter dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_icmp_reply_ready   (strobe),
    .i_icmp_reply_head    (head),
    .i_icmp_reply_payload (pay),
    .i_icmp_payload_size  (size),
    .o_tx_valid           (o_tx_valid),
    .i_tx_ready           (i_tx_ready),
    .o_tx_data            (o_tx_data),
    .o_tx_keep            (o_tx_keep),
    .o_tx_last            (o_tx_last),
    .o_busy               (o_busy),
    .o_dropped            (o_dropped)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ready driver: 0 = held high, 1 = held low, other = random
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = 1'b0;
      default: i_tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame as a byte array, sliced into words
  task automatic push_frame(input int n, input logic [399:0] h, input logic [503:0] p);
    logic [7:0]  fb[120];
    logic [63:0] d;
    logic [7:0]  k;
    int          len, words, cnt;
    for (int i = 0; i < 120; i++) fb[i] = 8'h00;
    for (int i = 0; i < 50; i++) fb[i] = h[399-8*i -: 8];
    for (int i = 0; i < n; i++) fb[50+i] = p[503-8*i -: 8];
    len   = 50 + n;
    words = (len + 7) / 8;
    for (int w = 0; w < words; w++) begin
      d = '0;
      for (int b = 0; b < 8; b++) d = {d[55:0], fb[8*w+b]};
      cnt = len - 8 * w;
      k = (cnt >= 8) ? 8'hFF : 8'(8'hFF << (8 - cnt));
      exp_q.push_back({(w == words - 1), k, d});
    end
  endtask

  function automatic logic [399:0] rand_head();
    logic [399:0] h;
    for (int i = 0; i < 50; i++) h[8*i +: 8] = 8'($urandom);
    h[399:336] = 64'h55555555555555D5;
    return h;
  endfunction

  function automatic logic [503:0] rand_pay();
    logic [503:0] p;
    for (int i = 0; i < 63; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  // driver tasks; every task starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int n, input logic [399:0] h, input logic [503:0] p);
    head = h; pay = p; size = 6'(n); strobe = 1'b1;
    step();
    strobe = 1'b0;
    push_frame(n, h, p);
  endtask

  task automatic drop_pulse();
    head = rand_head(); pay = rand_pay(); size = 6'($urandom_range(0, 63)); strobe = 1'b1;
    step();
    strobe = 1'b0;
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic wait_drain(input int bound, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < bound) begin
      @(negedge i_clk);
      #1;
      cycles++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 1, 0);
      exp_q.delete();
    end
    step();
  endtask

  task automatic directed(input string name, input int n, input logic [503:0] p, input int exp_words);
    int cycles;
    send(n, rand_head(), p);
    @(negedge i_clk);
    #1;
    chk({name, "_word0"}, o_tx_data, 64'h55555555555555D5);
    wait_drain(64, cycles);
    chk({name, "_cycles"}, cycles + 1, exp_words);
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        chk("tx_valid", o_tx_valid, 1);
        chk("tx_word", {o_tx_last, o_tx_keep, o_tx_data}, exp_q[0]);
        if (o_tx_valid && i_tx_ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_outputs", {o_tx_valid, o_tx_last, o_tx_keep, o_tx_data}, 0);
      end
      chk("busy_eq_valid", o_busy, o_tx_valid);
    end
  end

  initial begin
    logic [503:0] p;
    int           cycles, na, wa;

    i_reset = 1'b1;
    repeat (3) step();
    i_reset = 1'b0;
    mon_en = 1;
    @(negedge i_clk);
    #1;
    chk("reset_dropped", o_dropped, 0);
    chk("reset_valid", o_tx_valid, 0);
    step();

    // directed lengths, ready held high
    ready_mode = 0;
    step();
    directed("n6", 6, rand_pay(), 7);
    directed("n0", 0, rand_pay(), 7);
    p = '0;
    for (int i = 0; i < 63; i++) p[503-8*i -: 8] = 8'(i + 1);
    directed("n63", 63, p, 15);
    directed("n10", 10, rand_pay(), 8);

    // incrementing payload with random stalls
    ready_mode = 2;
    send(63, rand_head(), p);
    wait_drain(400, cycles);

    // random frames, random stalls
    for (int f = 0; f < 20; f++) begin
      send($urandom_range(0, 63), rand_head(), rand_pay());
      repeat ($urandom_range(0, 3)) step();
      wait_drain(400, cycles);
    end

    // single mid-frame drop
    ready_mode = 0;
    step();
    send(20, rand_head(), rand_pay());
    step();
    drop_pulse();
    wait_drain(64, cycles);
    chk("drop_one", o_dropped, exp_drop);

    // back-to-back frames chained on the last-word handshake
    for (int f = 0; f < 3; f++) begin
      na = $urandom_range(0, 63);
      wa = (50 + na + 7) / 8;
      send(na, rand_head(), rand_pay());
      repeat (wa - 1) step();
    end
    send($urandom_range(0, 63), rand_head(), rand_pay());
    wait_drain(100, cycles);
    chk("b2b_no_drop", o_dropped, exp_drop);

    // saturation of the drop counter
    ready_mode = 1;
    repeat (2) step();
    send(40, rand_head(), rand_pay());
    for (int i = 0; i < 300; i++) drop_pulse();
    chk("drop_sat", o_dropped, exp_drop);
    chk("drop_sat_255", o_dropped, 255);
    ready_mode = 0;
    wait_drain(64, cycles);

    // reset while word 3 is on the bus
    step();
    send(30, rand_head(), rand_pay());
    repeat (3) step();
    i_reset = 1'b1;
    step();
    exp_q.delete();
    exp_drop = 0;
    i_reset = 1'b0;
    @(negedge i_clk);
    #1;
    chk("midrst_valid", o_tx_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_dropped", o_dropped, 0);
    step();
    directed("after_rst", 25, rand_pay(), 10);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_icmp_reply_transmitter.md
# ethernet_icmp_reply_transmitter

Streams a completed ICMP echo reply onto the 64-bit MAC transmit interface. It captures the 50-byte reply head (preamble/SFD plus 42 header bytes) and up to 63 payload bytes from the reply builder on its one-cycle ready strobe. It then emits the frame as 64-bit words with byte-valid and last flags under a valid/ready handshake. It sits between the ICMP reply builder and the 10G TX MAC/FCS stage.

## Interface
Parameters:
- HEAD_BYTES, 50, reply head length in bytes (fixed by builder)
- PAYLOAD_MAX, 63, maximum payload bytes
- DROP_CNT_W, 8, width of saturating drop counter

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_icmp_reply_ready  in  1  one-cycle strobe: head/payload/size valid this cycle
- i_icmp_reply_head  in  400  head; byte 0 (first on wire) at [399:392]
- i_icmp_reply_payload  in  504  payload; byte 0 at [503:496], left-aligned
- i_icmp_payload_size  in  6  payload byte count N, 0..63
- o_tx_valid  out  1  word on o_tx_data valid
- i_tx_ready  in  1  downstream accepts word when valid&ready
- o_tx_data  out  64  frame bytes; earliest byte at [63:56]
- o_tx_keep  out  8  byte valid; bit 7 ↔ [63:56]
- o_tx_last  out  1  final word of frame
- o_busy  out  1  frame loaded and not fully accepted
- o_dropped  out  DROP_CNT_W  strobes ignored while busy, saturating

## Operation
- Frame length L = 50 + N (50..113); word count W = ceil(L/8) (7..15); last-word byte count R = L mod 8, with 0 → 8.
- FSM IDLE → SEND → IDLE.
- IDLE: on strobe, load 904-bit buffer {head, payload}. Payload bytes at index ≥ N are forced to zero on load. Set word counter = W−1, go to SEND.
- SEND: o_tx_valid=1; o_tx_data = buffer[903:840]. On valid&ready: shift buffer left 64 (zero fill) and decrement counter.
- o_tx_last=1 when counter==0. o_tx_keep = 8'hFF except on last word, where it is R ones from bit 7 downward (R=2 → 8'hC0, R=1 → 8'h80).
- Data bytes beyond L are always zero.
- Outputs are stable while valid&!ready. No word is skipped or repeated.
- Strobe in SEND, not coinciding with the last-word handshake: ignored, and o_dropped increments, saturating at all-ones.
- Strobe in the same cycle as the last-word handshake: accepted and loaded. FSM stays in SEND, and the next word is word 0 of the new frame. This is not a drop.
- N > 63 is impossible (6-bit).

## Timing
- Reset (sync): FSM=IDLE; o_tx_valid=0, o_tx_last=0, o_tx_keep=0, o_tx_data=0, o_busy=0, o_dropped=0; buffer cleared.
- Strobe at edge T → o_tx_valid=1 with word 0 from T+1.
- With i_tx_ready held high, one word per cycle: last word at T+W, o_busy low at T+W+1 unless reloaded.
- o_busy == o_tx_valid.
- Reset mid-frame aborts immediately: outputs go to reset values next cycle, and the partial frame is discarded with no o_tx_last.
- All outputs are registered; no combinational path from i_tx_ready to o_tx_valid.

## Structure
- Shared package: HEAD_BYTES, PAYLOAD_MAX, WORD_BYTES=8, BUF_BITS=904, and the FSM state enum (IDLE, SEND).
- Sub-module ethernet_tx_keep_gen: combinational map from (last flag, R[2:0]) to the 8-bit keep. It is reused by other reply transmitters (ARP).
- Core (buffer, counter, FSM, drop counter) in this module.

## Test plan
- N=6, ready held high: strobe → 7 words on consecutive cycles; word 0 = 64'h55555555555555D5; last keep 8'hFF, last flag on word 6 only.
- N=0: 7 words; last word keep 8'hC0 and carries head bytes 48–49 in [63:48], with [47:0]=0.
- N=63 with payload filled 0x01..0x3F: 15 words; last keep 8'h80, last byte 0x3F; random i_tx_ready stalls → identical byte stream, outputs held during stalls.
- N=10 with garbage in payload bytes 10..62: last word bytes after L are zero; keep 8'hF0.
- Strobe mid-frame → o_dropped 0→1, current frame unaffected. Strobe on the last-word handshake → back-to-back frames, o_tx_valid never drops, o_dropped unchanged. 300 mid-frame strobes → o_dropped saturates at 255.
- Reset asserted at word 3 → next cycle o_tx_valid=0, o_busy=0. A fresh strobe afterward yields a complete frame starting at word 0.
